// File: rtl/lsu_stage.sv
// ---------------------------------------------------------------------------
// lsu_stage -- load/store unit pipeline stage between execute and mem_wb.
//
// Accepts one instruction at a time over a valid/ready handshake and does one of:
//   * pass-through (non-memory opcode): result is presented the next cycle.
//   * load/store: issues one request on a simple req/gnt + rvalid memory port,
//     then presents the result (load data or pass-through data) downstream.
//   * misaligned access: no memory request, result flagged with exc_code 01.
//   * no grant/response within TIMEOUT cycles: access is abandoned and the
//     result is flagged with exc_code 10.
//
// Ports
//   clk, rstn                        clock, asynchronous active-low reset
//   in_valid / in_ready              upstream handshake
//   inst_i, instaddr_i, regs_wen_i,
//   rd_addr_i, rd_data_i, st_data_i  instruction, PC, writeback info,
//                                    effective address / ALU result, store data
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_be_o, mem_wdata_o, mem_gnt_i request channel (held stable until grant)
//   mem_rvalid_i, mem_rdata_i        response channel
//   out_valid / out_ready            downstream handshake
//   inst_o, instaddr_o, regs_wen_o,
//   rd_addr_o, rd_data_o             registered result towards mem_wb
//   exc_o, exc_code_o                exception flag and cause (01 misaligned,
//                                    10 timeout)
// ---------------------------------------------------------------------------
module lsu_stage #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         inst_i,
    input  logic [ADDR_W-1:0]   instaddr_i,
    input  logic                regs_wen_i,
    input  logic [4:0]          rd_addr_i,
    input  logic [DATA_W-1:0]   rd_data_i,
    input  logic [DATA_W-1:0]   st_data_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         inst_o,
    output logic [ADDR_W-1:0]   instaddr_o,
    output logic                regs_wen_o,
    output logic [4:0]          rd_addr_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                exc_o,
    output logic [1:0]          exc_code_o
);

    localparam int          BE_W     = DATA_W / 8;
    localparam int          LANE_W   = $clog2(BE_W);
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [1:0]  EXC_NONE     = 2'b00;
    localparam logic [1:0]  EXC_MISALIGN = 2'b01;
    localparam logic [1:0]  EXC_TIMEOUT  = 2'b10;
    // Last counter value at which the access may still complete; reaching it
    // without completion aborts, so REQ+WAIT last at most TIMEOUT cycles.
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t state_reg, state_next;

    // Captured access / result registers
    logic [31:0]       inst_reg;
    logic [ADDR_W-1:0] instaddr_reg;
    logic              regs_wen_reg;
    logic [4:0]        rd_addr_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              exc_reg;
    logic [1:0]        exc_code_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [BE_W-1:0]   be_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [7:0]        cnt_reg;

    // ---------------------------------------------------------------------
    // Decode of the incoming instruction
    // ---------------------------------------------------------------------
    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic [1:0]        size_in;
    logic              uns_in;
    logic [ADDR_W-1:0] eff_addr;
    logic [LANE_W-1:0] lane_in;
    logic              misaligned;
    logic              exc_in;
    logic [BE_W-1:0]   size_mask;
    logic [BE_W-1:0]   be_in;
    logic [DATA_W-1:0] wdata_in;
    logic [ADDR_W-1:0] aligned_addr;

    assign is_load      = (inst_i[6:0] == OP_LOAD);
    assign is_store     = (inst_i[6:0] == OP_STORE);
    assign is_mem       = is_load | is_store;
    assign size_in      = inst_i[13:12];
    assign uns_in       = inst_i[14];
    assign eff_addr     = ADDR_W'(rd_data_i);
    assign lane_in      = eff_addr[LANE_W-1:0];
    assign aligned_addr = {eff_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign exc_in       = is_mem & misaligned;

    // A dword access on a 32-bit port cannot be served, so it is reported
    // through the same misaligned exception path.
    always_comb begin
        misaligned = 1'b0;
        case (size_in)
            2'b01:   misaligned = eff_addr[0];
            2'b10:   misaligned = |eff_addr[1:0];
            2'b11:   misaligned = (DATA_W != 64) || (|eff_addr[2:0]);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        size_mask = '1;
        case (size_in)
            2'b00:   size_mask = BE_W'(1);
            2'b01:   size_mask = BE_W'(3);
            2'b10:   size_mask = BE_W'(15);
            default: size_mask = '1;
        endcase
    end

    assign be_in    = size_mask << lane_in;
    assign wdata_in = st_data_i << {lane_in, 3'b000};

    // ---------------------------------------------------------------------
    // Load data extraction: move the addressed lane to bit 0, then extend.
    // Casting a signed operand to a wider size sign-extends it.
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] rdata_shift;
    logic [DATA_W-1:0] load_data;

    assign rdata_shift = mem_rdata_i >> {lane_reg, 3'b000};

    always_comb begin
        load_data = rdata_shift;
        case (size_reg)
            2'b00: load_data = uns_reg ? DATA_W'(rdata_shift[7:0])
                                       : DATA_W'($signed(rdata_shift[7:0]));
            2'b01: load_data = uns_reg ? DATA_W'(rdata_shift[15:0])
                                       : DATA_W'($signed(rdata_shift[15:0]));
            2'b10: load_data = uns_reg ? DATA_W'(rdata_shift[31:0])
                                       : DATA_W'($signed(rdata_shift[31:0]));
            default: load_data = rdata_shift;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    logic accept;
    logic load_done;
    logic timeout_hit;
    logic ready_raw;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ready_raw   = 1'b0;
        out_valid   = 1'b0;
        mem_req_o   = 1'b0;
        load_done   = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready_raw = 1'b1;
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    if (we_reg) begin
                        state_next = ST_HOLD;
                    end else if (mem_rvalid_i) begin
                        // grant and response in the same cycle
                        load_done  = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else if (cnt_reg >= CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    load_done  = 1'b1;
                    state_next = ST_HOLD;
                end else if (cnt_reg >= CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    ready_raw  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Keep in_ready low while reset is held so every output reads 0.
        in_ready = ready_raw & rstn;
        accept   = in_valid & in_ready;
        if (accept) begin
            state_next = (is_mem && !misaligned) ? ST_REQ : ST_HOLD;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_reg     <= '0;
            instaddr_reg <= '0;
            regs_wen_reg <= 1'b0;
            rd_addr_reg  <= '0;
            rd_data_reg  <= '0;
            exc_reg      <= 1'b0;
            exc_code_reg <= EXC_NONE;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
            lane_reg     <= '0;
            size_reg     <= '0;
            uns_reg      <= 1'b0;
            cnt_reg      <= '0;
        end else if (accept) begin
            inst_reg     <= inst_i;
            instaddr_reg <= instaddr_i;
            regs_wen_reg <= regs_wen_i & ~exc_in;
            rd_addr_reg  <= rd_addr_i;
            rd_data_reg  <= rd_data_i;
            exc_reg      <= exc_in;
            exc_code_reg <= exc_in ? EXC_MISALIGN : EXC_NONE;
            we_reg       <= is_store;
            addr_reg     <= aligned_addr;
            be_reg       <= be_in;
            wdata_reg    <= wdata_in;
            lane_reg     <= lane_in;
            size_reg     <= size_in;
            uns_reg      <= uns_in;
            cnt_reg      <= '0;
        end else begin
            if (state_reg == ST_REQ || state_reg == ST_WAIT) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
            if (load_done) begin
                rd_data_reg <= load_data;
            end
            if (timeout_hit) begin
                exc_reg      <= 1'b1;
                exc_code_reg <= EXC_TIMEOUT;
                regs_wen_reg <= 1'b0;
            end
        end
    end

    // Memory-side signals are only driven while a request is outstanding.
    assign mem_we_o    = mem_req_o & we_reg;
    assign mem_addr_o  = mem_req_o ? addr_reg  : '0;
    assign mem_be_o    = mem_req_o ? be_reg    : '0;
    assign mem_wdata_o = mem_req_o ? wdata_reg : '0;

    assign inst_o      = inst_reg;
    assign instaddr_o  = instaddr_reg;
    assign regs_wen_o  = regs_wen_reg;
    assign rd_addr_o   = rd_addr_reg;
    assign rd_data_o   = rd_data_reg;
    assign exc_o       = exc_reg;
    assign exc_code_o  = exc_code_reg;

endmodule

// File: tb/tb_lsu_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_stage -- self-checking bench for lsu_stage (ADDR_W=32, DATA_W=32,
// TIMEOUT=15). Scenario tasks drive stimulus, push expected results into a
// scoreboard queue and do inline checks on memory-side behaviour; a negedge
// monitor pops the scoreboard on every output handshake.
// ---------------------------------------------------------------------------
module tb_lsu_stage;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_i;
    logic [31:0] instaddr_i;
    logic        regs_wen_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic [31:0] st_data_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_o;
    logic [31:0] instaddr_o;
    logic        regs_wen_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        exc_o;
    logic [1:0]  exc_code_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        exc;
        logic [1:0]  code;
    } exp_t;

    exp_t sb_q[$];

    // Instruction encodings
    localparam logic [31:0] I_ADDI = {12'h034, 5'd0, 3'b000, 5'd5, 7'b0010011};
    localparam logic [31:0] I_LB   = {12'h000, 5'd1, 3'b000, 5'd7, 7'b0000011};
    localparam logic [31:0] I_LBU  = {12'h000, 5'd1, 3'b100, 5'd7, 7'b0000011};
    localparam logic [31:0] I_LW   = {12'h000, 5'd1, 3'b010, 5'd3, 7'b0000011};
    localparam logic [31:0] I_SH   = {7'h00, 5'd2, 5'd1, 3'b001, 5'd0, 7'b0100011};

    lsu_stage #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inst_i       (inst_i),
        .instaddr_i   (instaddr_i),
        .regs_wen_i   (regs_wen_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_i    (rd_data_i),
        .st_data_i    (st_data_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .inst_o       (inst_o),
        .instaddr_o   (instaddr_o),
        .regs_wen_o   (regs_wen_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .exc_o        (exc_o),
        .exc_code_o   (exc_code_o)
    );

    always #5 clk = ~clk;

    // Output monitor: the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected got inst=%h data=%h required no output", inst_o, rd_data_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("[TB] out inst=%h pc=%h rd=%0d wen=%b data=%h exc=%b code=%b",
                         inst_o, instaddr_o, rd_addr_o, regs_wen_o, rd_data_o, exc_o, exc_code_o);
                if (inst_o !== e.inst || instaddr_o !== e.pc || regs_wen_o !== e.wen ||
                    rd_addr_o !== e.rd || exc_o !== e.exc || exc_code_o !== e.code ||
                    (e.chk_data && rd_data_o !== e.data)) begin
                    tests_failed++;
                    $display("FAIL sb_result got inst=%h pc=%h wen=%b rd=%0d data=%h exc=%b code=%b required inst=%h pc=%h wen=%b rd=%0d data=%h exc=%b code=%b",
                             inst_o, instaddr_o, regs_wen_o, rd_addr_o, rd_data_o, exc_o, exc_code_o,
                             e.inst, e.pc, e.wen, e.rd, e.data, e.exc, e.code);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] inst, input logic [31:0] pc, input logic wen,
                       input logic [4:0] rd, input logic [31:0] data, input logic [31:0] st);
        in_valid   = 1'b1;
        inst_i     = inst;
        instaddr_i = pc;
        regs_wen_i = wen;
        rd_addr_i  = rd;
        rd_data_i  = data;
        st_data_i  = st;
    endtask

    task automatic sb_push(input logic [31:0] inst, input logic [31:0] pc, input logic wen,
                           input logic [4:0] rd, input logic [31:0] data, input logic chk,
                           input logic exc, input logic [1:0] code);
        exp_t e;
        e.inst = inst; e.pc = pc; e.wen = wen; e.rd = rd;
        e.data = data; e.chk_data = chk; e.exc = exc; e.code = code;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; inst_i = '0; instaddr_i = '0; regs_wen_i = 1'b0;
        rd_addr_i = '0; rd_data_i = '0; st_data_i = '0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0; out_ready = 1'b1;
        #12;
        tests_run++;
        if ({out_valid, mem_req_o, mem_we_o, mem_be_o, exc_o, exc_code_o, regs_wen_o, in_ready} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got valid=%b req=%b we=%b be=%b exc=%b code=%b wen=%b rdy=%b required all 0",
                     out_valid, mem_req_o, mem_we_o, mem_be_o, exc_o, exc_code_o, regs_wen_o, in_ready);
        end
        tests_run++;
        if ({rd_data_o, inst_o, instaddr_o, mem_addr_o, mem_wdata_o, rd_addr_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data got data=%h inst=%h pc=%h addr=%h wdata=%h rd=%0d required all 0",
                     rd_data_o, inst_o, instaddr_o, mem_addr_o, mem_wdata_o, rd_addr_o);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        cycle();
    endtask

    task automatic test_passthrough();
        out_ready = 1'b1;
        put(I_ADDI, 32'h40, 1'b1, 5'd5, 32'h1234, 32'h0);
        sb_push(I_ADDI, 32'h40, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 2'b00);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL pt_in_ready got %b required 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || rd_data_o !== 32'h1234) begin
            tests_failed++;
            $display("FAIL pt_latency got valid=%b data=%h required 1 00001234", out_valid, rd_data_o);
        end
        tests_run++;
        if (mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL pt_no_req got mem_req_o=%b required 0", mem_req_o);
        end
        cycle();
        tests_run++;
        if (out_valid !== 1'b0 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL pt_done got valid=%b req=%b required 0 0", out_valid, mem_req_o);
        end
    endtask

    task automatic test_load_byte(input string name, input logic [31:0] inst, input logic [31:0] exp_data);
        put(inst, 32'h44, 1'b1, 5'd7, 32'h103, 32'h0);
        sb_push(inst, 32'h44, 1'b1, 5'd7, exp_data, 1'b1, 1'b0, 2'b00);
        cycle();
        in_valid = 1'b0;
        tests_run++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h100 || mem_be_o !== 4'b1000) begin
            tests_failed++;
            $display("FAIL %s_req got req=%b we=%b addr=%h be=%b required 1 0 00000100 1000",
                     name, mem_req_o, mem_we_o, mem_addr_o, mem_be_o);
        end
        mem_gnt_i = 1'b1;
        cycle();
        mem_gnt_i = 1'b0;
        tests_run++;
        if (mem_req_o !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_wait got req=%b valid=%b required 0 0", name, mem_req_o, out_valid);
        end
        cycle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h80FFFFFF;
        cycle();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_valid got %b required 1", name, out_valid);
        end
        cycle();
    endtask

    task automatic test_store_half();
        put(I_SH, 32'h48, 1'b0, 5'd0, 32'h202, 32'hABCD);
        sb_push(I_SH, 32'h48, 1'b0, 5'd0, 32'h202, 1'b1, 1'b0, 2'b00);
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h200 ||
                mem_be_o !== 4'b1100 || mem_wdata_o !== 32'hABCD0000) begin
                tests_failed++;
                $display("FAIL sh_req%0d got req=%b we=%b addr=%h be=%b wdata=%h required 1 1 00000200 1100 abcd0000",
                         i, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o);
            end
            if (i == 0) cycle();
        end
        mem_gnt_i = 1'b1;
        cycle();
        mem_gnt_i = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL sh_after_gnt got valid=%b req=%b required 1 0", out_valid, mem_req_o);
        end
        cycle();
    endtask

    task automatic test_misaligned();
        put(I_LW, 32'h4C, 1'b1, 5'd3, 32'h101, 32'h0);
        sb_push(I_LW, 32'h4C, 1'b0, 5'd3, 32'h0, 1'b0, 1'b1, 2'b01);
        cycle();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || exc_o !== 1'b1 || exc_code_o !== 2'b01 ||
            regs_wen_o !== 1'b0 || mem_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign got valid=%b exc=%b code=%b wen=%b req=%b required 1 1 01 0 0",
                     out_valid, exc_o, exc_code_o, regs_wen_o, mem_req_o);
        end
        cycle();
    endtask

    task automatic test_timeout();
        int n_req;
        n_req = 0;
        out_ready = 1'b0;
        put(I_LW, 32'h50, 1'b1, 5'd4, 32'h200, 32'h0);
        sb_push(I_LW, 32'h50, 1'b0, 5'd4, 32'h0, 1'b0, 1'b1, 2'b10);
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin
            if (mem_req_o === 1'b1) n_req++;
            cycle();
        end
        tests_run++;
        if (out_valid !== 1'b1 || n_req != TIMEOUT) begin
            tests_failed++;
            $display("FAIL to_req_cycles got valid=%b req_cycles=%0d required 1 %0d", out_valid, n_req, TIMEOUT);
        end
        tests_run++;
        if (mem_req_o !== 1'b0 || exc_o !== 1'b1 || exc_code_o !== 2'b10 || regs_wen_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_exc got req=%b exc=%b code=%b wen=%b required 0 1 10 0",
                     mem_req_o, exc_o, exc_code_o, regs_wen_o);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        cycle();
        mem_rvalid_i = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || rd_data_o === 32'hDEADBEEF || exc_code_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL to_late_rvalid_hold got valid=%b data=%h code=%b required 1 not-deadbeef 10",
                     out_valid, rd_data_o, exc_code_o);
        end
        out_ready = 1'b1;
        cycle();
        mem_rvalid_i = 1'b1;
        cycle();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_late_rvalid_idle got valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        put(I_ADDI, 32'h54, 1'b1, 5'd6, 32'hCAFE, 32'h0);
        sb_push(I_ADDI, 32'h54, 1'b1, 5'd6, 32'hCAFE, 1'b1, 1'b0, 2'b00);
        cycle();
        put(I_ADDI, 32'h58, 1'b1, 5'd8, 32'hBEEF, 32'h0);
        sb_push(I_ADDI, 32'h58, 1'b1, 5'd8, 32'hBEEF, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || rd_data_o !== 32'hCAFE ||
                rd_addr_o !== 5'd6 || instaddr_o !== 32'h54 || inst_o !== I_ADDI) begin
                tests_failed++;
                $display("FAIL stall%0d got valid=%b rdy=%b data=%h rd=%0d pc=%h required 1 0 0000cafe 6 00000054",
                         i, out_valid, in_ready, rd_data_o, rd_addr_o, instaddr_o);
            end
            cycle();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_in_ready got %b required 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || rd_data_o !== 32'hBEEF || rd_addr_o !== 5'd8) begin
            tests_failed++;
            $display("FAIL b2b_second got valid=%b data=%h rd=%0d required 1 0000beef 8",
                     out_valid, rd_data_o, rd_addr_o);
        end
        cycle();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain got valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        put({12'h000, 5'd1, 3'b010, 5'd9, 7'b0000011}, 32'h5C, 1'b1, 5'd9, 32'h300, 32'h0);
        cycle();
        in_valid = 1'b0;
        mem_gnt_i = 1'b1;
        cycle();
        mem_gnt_i = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, mem_req_o, mem_we_o, mem_be_o, exc_o, exc_code_o, regs_wen_o, in_ready,
             rd_data_o, inst_o, instaddr_o, rd_addr_o, mem_addr_o, mem_wdata_o} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid got valid=%b req=%b be=%b exc=%b data=%h inst=%h pc=%h required all 0",
                     out_valid, mem_req_o, mem_be_o, exc_o, rd_data_o, inst_o, instaddr_o);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        cycle();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_mid_after%0d got valid=%b rdy=%b req=%b required 0 1 0",
                         i, out_valid, in_ready, mem_req_o);
            end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte("lb",  I_LB,  32'hFFFFFF80);
        test_load_byte("lbu", I_LBU, 32'h00000080);
        test_store_half();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover got %0d pending required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the memory data width; legal values are 32 and 64.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles spent in REQ or WAIT before an access aborts; legal range is 1..255.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; every register samples on the rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- inst_i  in  32  instruction word.
- instaddr_i  in  ADDR_W  instruction PC.
- regs_wen_i  in  1  register write enable.
- rd_addr_i  in  5  destination register.
- rd_data_i  in  DATA_W  ALU result or effective address.
- st_data_i  in  DATA_W  store source data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  memory address, aligned to DATA_W/8.
- mem_be_o  out  DATA_W/8  memory byte enables.
- mem_wdata_o  out  DATA_W  lane-shifted store data.
- mem_gnt_i  in  1  memory request accepted.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  DATA_W  memory read data.
- out_valid  out  1  result valid to mem_wb.
- out_ready  in  1  mem_wb can accept.
- inst_o  out  32  registered inst_i.
- instaddr_o  out  ADDR_W  registered instaddr_i.
- regs_wen_o  out  1  registered regs_wen_i, gated by exceptions.
- rd_addr_o  out  5  registered rd_addr_i.
- rd_data_o  out  DATA_W  load data or pass-through data.
- exc_o  out  1  exception flag.
- exc_code_o  out  2  exception cause: 01 misaligned, 10 timeout.

Function
REQ-005 The block SHALL decode opcode inst_i[6:0]: 0000011 is a load, 0100011 is a store, and any other opcode is pass-through.
REQ-006 The block SHALL take access size from funct3[1:0] (00 byte, 01 half, 10 word, 11 dword, where dword is legal only when DATA_W=64) and signedness from funct3[2] (1 means zero-extend).
REQ-007 The FSM SHALL have states IDLE, REQ, WAIT and HOLD, and its reset state SHALL be IDLE.
REQ-008 The block SHALL drive in_ready=1 only in IDLE while no output is pending, or in the cycle the pending output handshakes (out_valid & out_ready).
REQ-009 On a pass-through accept, the block SHALL load the output registers with rd_data_o=rd_data_i and raise out_valid in the next cycle, giving 1-cycle latency.
REQ-010 On a load/store accept with an aligned address, the FSM SHALL go from IDLE to REQ and assert mem_req_o from the next cycle.
REQ-011 Misalignment SHALL be detected as half with addr[0]≠0, word with addr[1:0]≠0, or dword with addr[2:0]≠0.
REQ-012 On a misaligned access, the block SHALL issue no memory request and SHALL produce out_valid next cycle with exc_o=1, exc_code_o=01 and regs_wen_o=0.
REQ-013 In REQ, the block SHALL hold mem_req_o, mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o stable until mem_gnt_i.
REQ-014 When mem_gnt_i arrives in REQ, a store SHALL go to HOLD with its output valid, and a load SHALL go to WAIT.
REQ-015 In WAIT, mem_rvalid_i SHALL capture the extracted and extended load data and move the FSM to HOLD.
REQ-016 The block SHALL accept mem_rvalid_i in the same cycle as mem_gnt_i; in that case the FSM goes from REQ directly to HOLD.
REQ-017 The byte lane SHALL be addr[log2(DATA_W/8)-1:0]; the block SHALL build mem_be_o by shifting the size mask left by the lane, and mem_wdata_o by shifting st_data_i left by lane×8.
REQ-018 Load data SHALL be mem_rdata_i shifted right by lane×8, truncated to the access size, then sign- or zero-extended to DATA_W.
REQ-019 The timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-020 When the counter reaches TIMEOUT, the block SHALL drop mem_req_o, go to HOLD with exc_o=1, exc_code_o=10 and regs_wen_o=0, and ignore any later mem_rvalid_i for that access.
REQ-021 In HOLD, out_valid SHALL be 1 and the FSM SHALL return to IDLE on out_ready; when in_valid is also high in that cycle, the block SHALL accept the next instruction in that same cycle.
REQ-022 While out_valid=1 and out_ready=0, every output SHALL stay stable.
REQ-023 mem_req_o SHALL never be asserted for a pass-through instruction or while an exception is pending.

Reset
REQ-024 While rstn=0, the FSM SHALL be IDLE and every output SHALL be 0, including out_valid, mem_req_o, mem_we_o, mem_be_o, exc_o, exc_code_o, rd_data_o, inst_o and instaddr_o; in_ready SHALL be 1 after reset release.
REQ-025 A reset asserted mid-access SHALL abandon the access with no output; a response arriving after reset release SHALL be ignored.

Verification
REQ-026 The bench SHALL cover ADDI pass-through: rd_data_i=0x1234 -> out_valid one cycle later with rd_data_o=0x1234 and mem_req_o never asserted.
REQ-027 The bench SHALL cover LB from address 0x103 with mem_rdata_i=0x80FFFFFF, gnt and rvalid 2 cycles apart -> mem_addr_o=0x100, mem_be_o=1000, rd_data_o=0xFFFFFF80; LBU of the same gives rd_data_o=0x00000080.
REQ-028 The bench SHALL cover SH to 0x202 with st_data_i=0xABCD -> mem_be_o=1100, mem_wdata_o=0xABCD0000, mem_we_o=1, and out_valid the cycle after gnt.
REQ-029 The bench SHALL cover LW to 0x101 -> exc_o=1, exc_code_o=01, regs_wen_o=0, and no mem_req_o.
REQ-030 The bench SHALL cover a load with mem_gnt_i held 0 -> mem_req_o drops after TIMEOUT cycles, exc_code_o=10, and a late rvalid is ignored.
REQ-031 The bench SHALL cover out_ready held 0 for 3 cycles in HOLD -> outputs stable and in_ready=0; then rstn pulsed low during WAIT -> all outputs 0 and FSM IDLE.
